// File: rtl/conv_pkg.sv
// Shared widths and types for the conv_v2 arithmetic path (adder tree, channel
// accumulator, line buffer).
package conv_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned ChDefault = 4;

  // Accumulator width: full-scale window sums over ch channels plus a bias, no wrap.
  function automatic int unsigned acc_width(int unsigned data_w, int unsigned ch);
    return 2 * data_w + $clog2(ch) + 1;
  endfunction

  typedef logic signed [acc_width(DataW, ChDefault)-1:0] acc_t;
  typedef logic [DataW-1:0] act_t;

endpackage

// File: rtl/requant_sat.sv
// Rounded arithmetic right shift with ReLU and saturation to a positive
// DataW-bit activation.
module requant_sat
  import conv_pkg::*;
#(
  parameter int unsigned DataW = conv_pkg::DataW,
  parameter int unsigned AccW  = acc_width(DataW, ChDefault)
) (
  input  logic signed [AccW-1:0]  acc_i,
  input  logic        [4:0]       shift_i,
  output logic        [DataW-1:0] sat_o
);

  localparam logic signed [AccW:0] MaxAct = (AccW+1)'((1 << (DataW - 1)) - 1);

  logic signed [AccW:0] ext;
  logic signed [AccW:0] rnd;
  logic signed [AccW:0] r;

  always_comb begin
    ext = {acc_i[AccW-1], acc_i};
    rnd = '0;
    // Round half up: add half an output LSB before shifting.
    if (shift_i != 5'd0) rnd = (AccW+1)'(1) << (shift_i - 5'd1);
    r = (ext + rnd) >>> shift_i;
    if (r[AccW]) begin
      sat_o = '0;
    end else if (r > MaxAct) begin
      sat_o = MaxAct[DataW-1:0];
    end else begin
      sat_o = r[DataW-1:0];
    end
  end

endmodule

// File: rtl/conv_chan_acc.sv
// Per-filter channel accumulator: bias + pCH window sums, then ReLU and
// requantization to one activation per output pixel.
module conv_chan_acc
  import conv_pkg::*;
#(
  parameter int unsigned pDATA_W = conv_pkg::DataW,
  parameter int unsigned pCH     = conv_pkg::ChDefault,
  localparam int unsigned pACC_W = acc_width(pDATA_W, pCH)
) (
  input  logic                        iclk,
  input  logic                        irst_n,
  input  logic                        ien,
  input  logic                        iclear,
  input  logic                        ivalid,
  input  logic signed [2*pDATA_W-1:0] idata,
  input  logic signed [pACC_W-1:0]    ibias,
  input  logic        [4:0]           ishift,
  output logic        [pDATA_W-1:0]   odata,
  output logic                        ovalid,
  output logic                        obusy
);

  localparam int unsigned CntW = (pCH > 1) ? $clog2(pCH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(pCH - 1);

  logic signed [pACC_W-1:0]  acc_q, acc_d;
  logic        [CntW-1:0]    cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic        [pDATA_W-1:0] odata_q, odata_d;
  logic                      ovalid_q, ovalid_d;
  logic                      busy_q;

  logic signed [pACC_W-1:0]  data_ext;
  logic        [pDATA_W-1:0] sat;

  requant_sat #(
    .DataW(pDATA_W),
    .AccW (pACC_W)
  ) u_requant_sat (
    .acc_i  (acc_q),
    .shift_i(ishift),
    .sat_o  (sat)
  );

  assign data_ext = pACC_W'(idata);

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    if (iclear) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (ien) begin
      // Stage 2 consumes the pre-edge acc, so a new group may start on the same edge.
      ovalid_d = done_q;
      if (done_q) odata_d = sat;
      done_d = 1'b0;
      if (ivalid) begin
        acc_d = (cnt_q == '0) ? ibias + data_ext : acc_q + data_ext;
        if (cnt_q == CntLast) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      busy_q   <= (cnt_d != '0);
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign obusy  = busy_q;

endmodule

// File: doc/conv_chan_acc.md
Name: conv_chan_acc

Overview:
- Downstream stage of the 3x3 adder tree in the conv_v2 arithmetic path.
- Consumes one 3x3 window sum per input channel and accumulates pCH sums onto a per-filter bias.
- Applies ReLU, then a rounded arithmetic right-shift requantization with saturation.
- Emits one pDATA_W-bit activation per output pixel, with a single-cycle valid pulse, to the next layer's line buffer.

Parameters:
- pDATA_W, 8: activation width; input sum width is 2*pDATA_W.
- pCH, 4: number of input channels accumulated per output (>=1).
- pACC_W, 2*pDATA_W+$clog2(pCH)+1: signed accumulator width; derived, not overridden.

Ports:
- iclk  input  1  clock.
- irst_n  input  1  synchronous active-low reset.
- ien  input  1  pipeline enable, same signal that drives the adder tree.
- iclear  input  1  synchronous abort of the current group.
- ivalid  input  1  idata beat valid; aligned with the adder-tree output latency.
- idata  input  2*pDATA_W  signed window sum for one channel.
- ibias  input  pACC_W  signed bias; sampled on the first beat of a group.
- ishift  input  5  requant right-shift amount, 0..2*pDATA_W; static per group.
- odata  output  pDATA_W  requantized activation, unsigned range 0..2^(pDATA_W-1)-1.
- ovalid  output  1  one-cycle pulse, odata valid.
- obusy  output  1  high while a group is partially accumulated (cnt!=0).

Behaviour:
- Clock and reset: single clock iclk. Reset is synchronous and active-low (irst_n). All state is sampled on posedge iclk.
- Reset (irst_n=0): acc=0, cnt=0, done=0, odata=0, ovalid=0, obusy=0. Reset mid-group discards the partial sum; no ovalid is produced for it.
- Priority: irst_n > iclear > ien gating > ivalid.
- Stage 1 (accumulate), on an edge with ien=1 and ivalid=1:
  - cnt==0: acc <= sext(ibias) + sext(idata).
  - otherwise: acc <= acc + sext(idata).
  - cnt==pCH-1: cnt <= 0 and done <= 1. Otherwise cnt <= cnt+1 and done <= 0.
  - pCH=1: every beat is both first and last.
- Stage 2 (output), on an edge with ien=1:
  - ovalid <= done.
  - If done=1: odata <= requant(acc, ishift); done is cleared unless stage 1 sets it again on the same edge.
- requant:
  - r = (acc + (ishift>0 ? 1<<(ishift-1) : 0)) >>> ishift, computed at pACC_W+1 bits (round half up).
  - r<0 gives 0 (ReLU).
  - r>2^(pDATA_W-1)-1 gives 2^(pDATA_W-1)-1.
  - Otherwise r[pDATA_W-1:0].
- Latency: last beat sampled at edge E; ovalid=1 and odata valid for exactly one cycle after edge E+1.
- Back-to-back groups: a new group's first beat at edge E+1 is legal. Stage 2 reads the pre-edge acc, so no bubble is needed; sustained rate is one output per pCH beats.
- ivalid=0 with ien=1: acc and cnt hold. A pending done still fires.
- ien=0: acc, cnt, done and odata hold; ovalid <= 0. A pending result fires on the first edge with ien=1. ivalid is ignored while ien=0.
- iclear=1 (with irst_n=1): cnt <= 0, done <= 0, ovalid <= 0; that edge's ivalid beat is dropped; odata holds.
- odata holds its last value between pulses.
- obusy = (cnt!=0), registered with cnt.
- Overflow: pACC_W guarantees no wrap for pCH full-scale sums plus a bias of at most 2*pDATA_W bits of magnitude. Larger biases are out of contract.

Decomposition:
- conv_pkg holds:
  - default pDATA_W;
  - function acc_width(data_w, ch);
  - typedef for signed accumulator and activation types shared with the adder tree and line buffer.
- One combinational sub-module, requant_sat (acc, shift -> sat activation), instantiated in stage 2 and reused by later layers.

Test Plan:
All scenarios use pDATA_W=8, pCH=4.
1. Reset: irst_n low 2 edges mid-group with cnt=2 -> odata=0, ovalid=0, obusy=0; the next 4 beats form a fresh group.
2. Basic: ibias=10, ishift=0, beats 5,6,7,8 back-to-back -> single ovalid pulse one edge after the 4th beat, odata=36.
3. ReLU: ibias=0, beats -100,-50,20,10 (sum -120) -> ovalid pulse, odata=0.
4. Rounding and saturation:
   - ishift=4, beats 10,10,10,10 (40): (40+8)>>4 -> odata=3.
   - beats 1000 x4 (4000): 250 -> odata=127.
5. Stall and streaming:
   - Two groups back-to-back -> two pulses exactly 4 cycles apart.
   - Repeat with ien=0 for 3 cycles between beats 2 and 3, and again for 1 cycle after the last beat -> identical odata, pulses delayed by the stall cycles, ovalid never high while ien=0.
6. Abort: 2 beats, then iclear with ivalid=1 -> no pulse; following group bias=0 with beats 1,2,3,4 -> odata=10; obusy follows cnt throughout.
